// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Brief    : Pipeline stall/flush sequencer with divider handshake watchdog.
//            Optional perf counters enabled by CTRL_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
    parameter int DIV_TIMEOUT = 40,
    parameter int TOCNT_W     = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        div_start_i,
    input  logic        div_ready_i,
    input  logic        flush_req_i,
    input  logic [31:0] handler_addr_i,
    output logic [5:0]  stall_o,
    output logic        div_cancel_o,
    output logic        div_timeout_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_count_o
`endif
);

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_DIV_WAIT = 1'b1
    } state_t;

    localparam logic [TOCNT_W-1:0] C_CNT_LAST = TOCNT_W'(DIV_TIMEOUT - 1);
    localparam logic [5:0]         C_STALL_EX = 6'b001111;
    localparam logic [5:0]         C_STALL_ID = 6'b000111;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TOCNT_W-1:0] r_cnt;
    logic [TOCNT_W-1:0] w_cnt_nxt;
    logic               w_div_pending;
    logic               w_cancel;
    logic               w_timeout;
    logic [5:0]         w_stall;
    logic               r_flush;
    logic [31:0]        r_new_pc;
    logic               r_div_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_flush       <= 1'b0;
            r_new_pc      <= '0;
            r_div_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_flush       <= flush_req_i;
            r_div_timeout <= w_timeout;
            if (flush_req_i) begin
                r_new_pc <= handler_addr_i;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_div_pending = 1'b0;
        w_cancel      = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_div_pending = div_start_i;
                if (div_start_i) begin
                    if (flush_req_i) begin
                        w_cancel = 1'b1;
                    end else begin
                        w_state_nxt = S_DIV_WAIT;
                    end
                end
            end
            S_DIV_WAIT: begin
                w_div_pending = ~div_ready_i;
                w_cnt_nxt     = r_cnt + TOCNT_W'(1);
                // Flush outranks a simultaneous ready: the result belongs to a squashed instruction.
                if (flush_req_i) begin
                    w_cancel    = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (div_ready_i) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_cancel    = 1'b1;
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_stall = 6'b000000;
        if (flush_req_i) begin
            w_stall = 6'b000000;
        end else if (w_div_pending || stallreq_ex_i) begin
            w_stall = C_STALL_EX;
        end else if (stallreq_id_i) begin
            w_stall = C_STALL_ID;
        end
    end

    assign stall_o       = rst ? 6'b000000 : w_stall;
    assign div_cancel_o  = w_cancel & ~rst;
    assign div_timeout_o = r_div_timeout;
    assign flush_o       = r_flush;
    assign new_pc_o      = r_new_pc;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (stall_o[0]) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (r_flush) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stall_cycles_o = r_stall_cycles;
    assign flush_count_o  = r_flush_count;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central pipeline sequencing controller for the 5-stage core. It generates the stall[5:0] vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb, and sequences multi-cycle EX operations (divider) through a start/ready handshake with a watchdog. It also arbitrates exception flushes against outstanding stalls and produces the flush pulse and redirect PC.

Parameters:
DIV_TIMEOUT, 40, max cycles in DIV_WAIT before abort (>=2)
TOCNT_W, 6, width of the watchdog counter; must hold DIV_TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  reset; rst synchronous, active-high (RstEnable=1); clock clk
stallreq_id_i  in  1  load-use hazard request from ID
stallreq_ex_i  in  1  generic single-cycle stall request from EX (e.g. madd/msub second cycle)
div_start_i  in  1  EX issues a divide this cycle
div_ready_i  in  1  divider result valid this cycle
flush_req_i  in  1  exception detected in MEM
handler_addr_i  in  32  exception vector / EPC target
stall_o  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (always 0); 1=Stop
div_cancel_o  out  1  abort in-flight divide
div_timeout_o  out  1  one-cycle pulse, watchdog expired
flush_o  out  1  one-cycle flush pulse to all pipeline registers
new_pc_o  out  32  redirect PC, valid while flush_o=1

Behaviour:
- FSM states: IDLE, DIV_WAIT. State, watchdog counter, flush_o, new_pc_o and div_timeout_o are registered; stall_o and div_cancel_o are combinational from state and inputs.
- Reset: state=IDLE, counter=0, flush_o=0, new_pc_o=0, div_timeout_o=0, div_cancel_o=0, stall_o=6'b000000. Reset mid-divide returns to IDLE with no cancel pulse.
- stall_o priority (highest first):
  - flush_req_i=1 -> 6'b000000.
  - Divide pending (state=DIV_WAIT and div_ready_i=0, or state=IDLE and div_start_i=1) -> 6'b001111.
  - stallreq_ex_i=1 -> 6'b001111.
  - stallreq_id_i=1 -> 6'b000111.
  - Otherwise 6'b000000.
- IDLE:
  - div_start_i=1 and flush_req_i=0 -> DIV_WAIT, counter=0.
  - div_start_i and flush_req_i both 1 -> stay IDLE; div_cancel_o=1.
- DIV_WAIT:
  - Counter increments each cycle.
  - div_ready_i=1 -> IDLE, with stall released in the same cycle so ex_mem captures the result.
  - flush_req_i=1 -> div_cancel_o=1 combinationally, then IDLE. Flush wins over a simultaneous div_ready_i.
  - Counter reaches DIV_TIMEOUT-1 with no ready -> div_timeout_o=1 next cycle, div_cancel_o=1 this cycle, then IDLE.
- Flush: flush_req_i=1 in any state -> next cycle flush_o=1 and new_pc_o=handler_addr_i, for exactly one cycle.
  - Back-to-back flush_req_i gives back-to-back pulses, each carrying its own address.
  - new_pc_o holds its last value when flush_o=0.
- div_start_i while already in DIV_WAIT is ignored (EX is stalled and cannot issue).

Optional Feature:
Macro CTRL_PERF_CNT_EN.
- Defined: adds outputs stall_cycles_o[31:0] and flush_count_o[31:0].
  - stall_cycles_o increments each cycle stall_o[0]=1.
  - flush_count_o increments each flush_o pulse.
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: rst=1 for 3 cycles with every input active -> stall_o=0, flush_o=0, new_pc_o=0, state IDLE.
- Load-use: stallreq_id_i=1 for 1 cycle -> stall_o=6'b000111 that cycle, 0 the next.
- Divide: div_start_i at T0, div_ready_i at T0+33 -> stall_o=6'b001111 over T0..T0+32 and 0 at T0+33; no cancel, no timeout.
- Timeout: DIV_TIMEOUT=8, div_start_i with no ready -> div_cancel_o=1 on the 8th DIV_WAIT cycle, div_timeout_o=1 the following cycle, stall_o=0 afterwards.
- Flush during divide: flush_req_i with handler_addr_i=32'h0000_0020 on the same cycle as div_ready_i -> div_cancel_o=1, stall_o=0, then next cycle flush_o=1 and new_pc_o=32'h20.
- Perf counters (CTRL_PERF_CNT_EN): 5 load-use stalls plus 2 flushes -> stall_cycles_o=5, flush_count_o=2.
